// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU datapath types and constants for the sequential divider
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 32;

    // Quotient reported when the divisor is zero
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    // Iteration counter must hold the value WIDTH itself
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_width(DIV_WIDTH);

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one combinational restoring-division step
module divider_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;
    logic             fits;

    // Shift the next dividend bit into the partial remainder, trial-subtract, restore on borrow
    always_comb begin
        rem_sh = {rem_i, q_i[WIDTH-1]};
        diff   = rem_sh - {2'b00, dvsr_i};
        fits   = ~diff[WIDTH+1];
        rem_o  = fits ? diff[WIDTH:0] : rem_sh[WIDTH:0];
        q_o    = {q_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - sequential restoring divider, signed/unsigned, start/busy/done handshake
module divider_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] wq_q, wq_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic             dvsr_zero;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_q;

    // Operand magnitudes; signed mode works on absolute values and fixes signs at the end
    always_comb begin
        mag_a     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        mag_b     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        dvsr_zero = (divisor == '0);
    end

    divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .q_i    (wq_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    // Next-state and next-output logic for the IDLE/RUN/FIX sequence
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        wq_d          = wq_q;
        dvsr_d        = dvsr_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        zero_d        = zero_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    wq_d      = mag_a;
                    dvsr_d    = mag_b;
                    neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed & dividend[WIDTH-1];
                    zero_d    = dvsr_zero;
                    // On divide-by-zero the dividend magnitude parks in the remainder so the
                    // normal sign fix-up returns the original dividend unchanged
                    rem_d     = dvsr_zero ? {1'b0, mag_a} : '0;
                    cnt_d     = CNT_W'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = dvsr_zero ? FIX : RUN;
                end
            end
            RUN: begin
                rem_d = step_rem;
                wq_d  = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d    = zero_q ? '1 : (neg_quo_q ? -wq_q : wq_q);
                remainder_d   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                div_by_zero_d = zero_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            wq_q          <= '0;
            dvsr_q        <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            zero_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            wq_q          <= wq_d;
            dvsr_q        <= dvsr_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            zero_q        <= zero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - self-checking bench for divider_seq
module tb_divider_seq;

    localparam int W    = 32;
    localparam int LAT  = W + 1;
    localparam int TOUT = 80;

    logic         clk;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    divider_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           s;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        bit           ez;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: plain language-level division on wide integers
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            z  = 1'b0;
        end else begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            q  = W'(ua / ub);
            r  = W'(ua % ub);
            z  = 1'b0;
        end
    endfunction

    // Count edges after acceptance until done; optionally poke a stray start at edge poke_at
    task automatic wait_done(input int poke_at, output int k, output bit busy_ok);
        k       = 0;
        busy_ok = busy;
        while (!done && k < TOUT) begin
            @(posedge clk);
            #1;
            k++;
            if (!done && !busy) busy_ok = 1'b0;
            if (k == poke_at) begin
                start    = 1'b1;
                dividend = 32'd999;
                divisor  = 32'd1;
            end else if (poke_at > 0) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input int poke_at,
                         output logic [W-1:0] gq, output logic [W-1:0] gr, output bit gz);
        int k;
        bit bo;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b; is_signed = s;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
        wait_done(poke_at, k, bo);
        check("latency", W'(k), (b == 0) ? W'(1) : W'(LAT));
        check("busy_in_flight", W'(bo), W'(1));
        check("busy_at_done", W'(busy), W'(0));
        gq = quotient; gr = remainder; gz = div_by_zero;
        @(posedge clk);
        #1;
        check("done_one_cycle", W'(done), W'(0));
        check("quotient_held", quotient, gq);
    endtask

    initial begin
        logic [W-1:0] gq, gr, eq, er;
        bit           gz, ez, bo, seen;
        int           k, sel;
        logic [W-1:0] a, b;
        bit           s;

        tbl[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        tbl[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        tbl[2] = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0};
        tbl[3] = '{32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          1'b1};
        tbl[4] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        tbl[5] = '{32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1};
        tbl[6] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
        tbl[7] = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0};
        tbl[8] = '{32'd3,          32'hFFFFFFFF,   1'b0, 32'd0,          32'd3,          1'b0};

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_quotient", quotient, W'(0));
        check("rst_remainder", remainder, W'(0));
        check("rst_div_by_zero", W'(div_by_zero), W'(0));
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors
        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].s, 0, gq, gr, gz);
            check($sformatf("vec%0d_q", i), gq, tbl[i].eq);
            check($sformatf("vec%0d_r", i), gr, tbl[i].er);
            check($sformatf("vec%0d_dbz", i), W'(gz), W'(tbl[i].ez));
        end

        // Stray start mid-operation is ignored
        do_op(32'd1000, 32'd13, 1'b0, 10, gq, gr, gz);
        check("ignore_start_q", gq, 32'd76);
        check("ignore_start_r", gr, 32'd12);

        // Start held high through done: second operation accepted straight away
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd7; is_signed = 1'b0;
        @(posedge clk);
        #1;
        dividend = 32'hFFFFFFAD; divisor = 32'd9; is_signed = 1'b1;
        k = 0;
        while (!done && k < TOUT) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("hold_first_lat", W'(k), W'(LAT));
        check("hold_first_q", quotient, 32'd142);
        check("hold_first_r", remainder, 32'd6);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_second_busy", W'(busy), W'(1));
        check("hold_second_done_low", W'(done), W'(0));
        wait_done(0, k, bo);
        check("hold_second_lat", W'(k + 1), W'(LAT + 1));
        check("hold_second_q", quotient, 32'hFFFFFFF7);
        check("hold_second_r", remainder, 32'hFFFFFFFE);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; dividend = 32'd5000; divisor = 32'd3; is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_busy", W'(busy), W'(0));
        check("arst_done", W'(done), W'(0));
        check("arst_quotient", quotient, W'(0));
        check("arst_remainder", remainder, W'(0));
        check("arst_div_by_zero", W'(div_by_zero), W'(0));
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("arst_no_done", W'(seen), W'(0));
        do_op(32'd5000, 32'd3, 1'b0, 0, gq, gr, gz);
        check("arst_fresh_q", gq, 32'd1666);
        check("arst_fresh_r", gr, 32'd2);

        // Randomized operations against the reference
        for (int n = 0; n < 30; n++) begin
            a   = $urandom;
            s   = 1'($urandom);
            sel = $urandom_range(0, 5);
            case (sel)
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = -W'($urandom_range(1, 15));
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if (n == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; s = 1'b1; end
            ref_div(a, b, s, eq, er, ez);
            do_op(a, b, s, 0, gq, gr, gz);
            check($sformatf("rnd%0d_q", n), gq, eq);
            check($sformatf("rnd%0d_r", n), gr, er);
            check($sformatf("rnd%0d_dbz", n), W'(gz), W'(ez));
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
